// File: rtl/lsu.sv
// lsu: load/store unit between decode/ALU and a valid/ready memory bus.
// FSM IDLE -> REQ -> DONE with all outputs registered.
// Optional feature: define MISALIGN_TRAP_EN to fault misaligned H/HU/W
// accesses without touching the bus; undefined, low address bits that a
// halfword or word access does not use are ignored.
//
// Bus handshake: the unit raises mem_valid and holds mem_valid,
// mem_addr, mem_wdata and mem_wstrb stable until a posedge where
// mem_valid && mem_ready; that edge is the transfer (mem_rdata is
// sampled there for loads) and mem_valid drops right after it.
// mem_ready while mem_valid is low has no effect.
module lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 255   // 0 disables the timeout
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] address,
   input  logic [31:0] store_data,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   output logic [31:0] load_result,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Wait counter is at least 8 bits, wider only if the limit needs it.
   localparam int unsigned CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CW:0] TO_LIM = (CW+1)'(TIMEOUT_CYCLES);

   state_t          state;
   logic            op_load;
   logic [2:0]      f3_q;
   logic [1:0]      addr_lo_q;
   logic [CW-1:0]   wait_cnt;

   logic            one_op;
   logic            f3_legal;
   logic            misalign;
   logic            reject;
   logic [3:0]      st_strb;
   logic [31:0]     st_wdata;
   logic [CW:0]     cnt_inc;
   logic            timeout_hit;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [31:0]     ld_ext;

   assign dbg_state = state;

   // Decode the incoming request: legality, alignment and store lanes.
   always_comb begin
      one_op   = is_load ^ is_store;
      f3_legal = 1'b0;
      if (is_load) begin
         case (funct3)
            3'd0, 3'd1, 3'd2, 3'd4, 3'd5: f3_legal = 1'b1;
            default:                      f3_legal = 1'b0;
         endcase
      end else begin
         f3_legal = (funct3 <= 3'd2);
      end
`ifdef MISALIGN_TRAP_EN
      misalign = ((funct3[1:0] == 2'd1) && address[0]) ||
                 ((funct3[1:0] == 2'd2) && (address[1:0] != 2'b00));
`else
      misalign = 1'b0;
`endif
      reject   = !f3_legal || misalign;
      st_strb  = 4'b1111;
      st_wdata = store_data;
      case (funct3[1:0])
         2'd0: begin
            st_strb  = 4'b0001 << address[1:0];
            st_wdata = {4{store_data[7:0]}};
         end
         2'd1: begin
            st_strb  = 4'b0011 << {address[1], 1'b0};
            st_wdata = {2{store_data[15:0]}};
         end
         default: begin
            st_strb  = 4'b1111;
            st_wdata = store_data;
         end
      endcase
   end

   // Timeout compare on the count this cycle would produce.
   always_comb begin
      cnt_inc     = {1'b0, wait_cnt} + {{CW{1'b0}}, 1'b1};
      timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TO_LIM);
   end

   // Select the load lane from the latched address and extend it.
   always_comb begin
      case (addr_lo_q)
         2'd0:    ld_byte = mem_rdata[7:0];
         2'd1:    ld_byte = mem_rdata[15:8];
         2'd2:    ld_byte = mem_rdata[23:16];
         default: ld_byte = mem_rdata[31:24];
      endcase
      ld_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (f3_q)
         3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
         3'd4:    ld_ext = {24'd0, ld_byte};
         3'd5:    ld_ext = {16'd0, ld_half};
         default: ld_ext = mem_rdata;
      endcase
   end

   // FSM and every registered output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         op_load     <= 1'b0;
         f3_q        <= 3'd0;
         addr_lo_q   <= 2'd0;
         wait_cnt    <= '0;
         mem_valid   <= 1'b0;
         mem_addr    <= 32'd0;
         mem_wdata   <= 32'd0;
         mem_wstrb   <= 4'd0;
         load_result <= 32'd0;
         busy        <= 1'b0;
         done        <= 1'b0;
         fault       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && one_op) begin
                  op_load   <= is_load;
                  f3_q      <= funct3;
                  addr_lo_q <= address[1:0];
                  wait_cnt  <= '0;
                  busy      <= 1'b1;
                  if (reject) begin
                     // Illegal or trapped access: skip the bus entirely.
                     state <= S_DONE;
                     done  <= 1'b1;
                     fault <= 1'b1;
                  end else begin
                     state     <= S_REQ;
                     mem_valid <= 1'b1;
                     mem_addr  <= {address[31:2], 2'b00};
                     mem_wstrb <= is_load ? 4'b0000 : st_strb;
                     mem_wdata <= is_load ? 32'd0 : st_wdata;
                  end
               end
            end
            S_REQ: begin
               if (mem_ready) begin
                  // Transfer beats a timeout landing on the same edge.
                  mem_valid <= 1'b0;
                  state     <= S_DONE;
                  done      <= 1'b1;
                  if (op_load) begin
                     load_result <= ld_ext;
                  end
               end else if (timeout_hit) begin
                  mem_valid <= 1'b0;
                  state     <= S_DONE;
                  done      <= 1'b1;
                  fault     <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
               fault <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state     <= S_IDLE;
               mem_valid <= 1'b0;
               done      <= 1'b0;
               fault     <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed table of load/store transactions against lsu plus
// hand-written sequences for illegal start, and reset during REQ.
// The DUT runs with an 8-cycle timeout so delayed accesses and the
// timeout/ready tie fit in one build.
module tb_lsu;

   localparam int TO = 8;

   logic        clk;
   logic        rst;
   logic        start;
   logic        is_load;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] address;
   logic [31:0] store_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic [31:0] load_result;
   logic        busy;
   logic        done;
   logic        fault;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   lsu #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
      .funct3(funct3), .address(address), .store_data(store_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
      .load_result(load_result), .busy(busy), .done(done), .fault(fault),
      .dbg_state(dbg_state)
   );

   // Clock and watchdog.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200000, required finished");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit          ld;
      bit          st;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] sd;
      int          dly;
      logic [31:0] rd;
      bit          poke;
      bit          bus;
      logic [31:0] e_addr;
      logic [3:0]  e_strb;
      logic [31:0] e_wdata;
      bit          e_fault;
      int          e_done;
      logic [31:0] e_res;
   } vec_t;

   typedef struct {
      int          valid_cycles;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
      bit          unstable;
      int          done_cyc;
      logic        done_seen;
      logic        fault;
      logic        busy;
      logic [31:0] result;
   } obs_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit ld, bit st, logic [2:0] f3, logic [31:0] a, logic [31:0] sd,
                               int dly, logic [31:0] rd, bit poke, bit bus, logic [31:0] e_addr,
                               logic [3:0] e_strb, logic [31:0] e_wdata, bit e_fault, int e_done,
                               logic [31:0] e_res);
      vec_t v;
      v.ld = ld; v.st = st; v.f3 = f3; v.a = a; v.sd = sd; v.dly = dly; v.rd = rd;
      v.poke = poke; v.bus = bus; v.e_addr = e_addr; v.e_strb = e_strb;
      v.e_wdata = e_wdata; v.e_fault = e_fault; v.e_done = e_done; v.e_res = e_res;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   // Driver: start pulse, then answer mem_valid with ready after dly
   // waiting cycles; cycle 0 is the start cycle, sampling on negedges.
   task automatic run_txn(input vec_t v, output obs_t o);
      int cyc;
      o.valid_cycles = 0; o.addr = '0; o.strb = '0; o.wdata = '0; o.unstable = 0;
      o.done_cyc = 0; o.done_seen = 0; o.fault = 0; o.busy = 0; o.result = '0;
      @(negedge clk);
      start = 1'b1; is_load = v.ld; is_store = v.st; funct3 = v.f3;
      address = v.a; store_data = v.sd; mem_ready = 1'b0; mem_rdata = v.rd;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 60) begin
         if (mem_valid) begin
            if (o.valid_cycles == 0) begin
               o.addr = mem_addr; o.strb = mem_wstrb; o.wdata = mem_wdata;
            end else if (mem_addr !== o.addr || mem_wstrb !== o.strb || mem_wdata !== o.wdata) begin
               o.unstable = 1;
            end
            o.valid_cycles++;
            mem_ready = (o.valid_cycles == v.dly + 1);
         end else begin
            mem_ready = 1'b0;
         end
         // Stray start mid-access, with a different operation on the inputs.
         start = v.poke && (o.valid_cycles == 3);
         if (start) begin
            is_load = 1'b0; is_store = 1'b1; funct3 = 3'd2; address = 32'hFFFF_FFF0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      mem_ready = 1'b0;
      o.done_cyc = cyc; o.done_seen = done; o.fault = fault; o.busy = busy;
      o.result = load_result;
   endtask

   obs_t o;
   logic [31:0] exp_res;

   initial begin
      rst = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0;
      address = '0; store_data = '0; mem_ready = 1'b0; mem_rdata = '0;

      //        ld st f3  addr          sdata         dly rdata         pk bus e_addr        strb     wdata         flt done result
      vecs.push_back(mk(0, 1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 0, 32'h0,         0, 1, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 0, 2, 32'h0));
      vecs.push_back(mk(0, 1, 3'd1, 32'h0000_1002, 32'h1234_BEEF, 1, 32'h0,         0, 1, 32'h0000_1000, 4'b1100, 32'hBEEF_BEEF, 0, 3, 32'h0));
      vecs.push_back(mk(0, 1, 3'd2, 32'h0000_1004, 32'hDEAD_BEEF, 0, 32'h0,         0, 1, 32'h0000_1004, 4'b1111, 32'hDEAD_BEEF, 0, 2, 32'h0));
      vecs.push_back(mk(0, 1, 3'd0, 32'h0000_1000, 32'h1234_5677, 0, 32'h0,         0, 1, 32'h0000_1000, 4'b0001, 32'h7777_7777, 0, 2, 32'h0));
      vecs.push_back(mk(1, 0, 3'd0, 32'h0000_2001, 32'h0,         0, 32'h0000_80FF, 0, 1, 32'h0000_2000, 4'b0000, 32'h0,         0, 2, 32'hFFFF_FF80));
      vecs.push_back(mk(1, 0, 3'd4, 32'h0000_2001, 32'h0,         0, 32'h0000_80FF, 0, 1, 32'h0000_2000, 4'b0000, 32'h0,         0, 2, 32'h0000_0080));
      vecs.push_back(mk(1, 0, 3'd5, 32'h0000_2002, 32'h0,         0, 32'hBEEF_1234, 0, 1, 32'h0000_2000, 4'b0000, 32'h0,         0, 2, 32'h0000_BEEF));
      vecs.push_back(mk(1, 0, 3'd1, 32'h0000_2000, 32'h0,         0, 32'hBEEF_8001, 0, 1, 32'h0000_2000, 4'b0000, 32'h0,         0, 2, 32'hFFFF_8001));
      vecs.push_back(mk(1, 0, 3'd0, 32'h0000_2000, 32'h0,         0, 32'h0000_007F, 0, 1, 32'h0000_2000, 4'b0000, 32'h0,         0, 2, 32'h0000_007F));
      vecs.push_back(mk(1, 0, 3'd2, 32'h0000_2004, 32'h0,         2, 32'hCAFE_F00D, 0, 1, 32'h0000_2004, 4'b0000, 32'h0,         0, 4, 32'hCAFE_F00D));
      vecs.push_back(mk(1, 0, 3'd3, 32'h0000_2000, 32'h0,         0, 32'h1111_1111, 0, 0, 32'h0,         4'b0000, 32'h0,         1, 1, 32'hCAFE_F00D));
      vecs.push_back(mk(0, 1, 3'd4, 32'h0000_2000, 32'h1,         0, 32'h0,         0, 0, 32'h0,         4'b0000, 32'h0,         1, 1, 32'hCAFE_F00D));
      vecs.push_back(mk(1, 0, 3'd7, 32'h0000_2000, 32'h0,         0, 32'h2222_2222, 0, 0, 32'h0,         4'b0000, 32'h0,         1, 1, 32'hCAFE_F00D));
`ifdef MISALIGN_TRAP_EN
      vecs.push_back(mk(1, 0, 3'd2, 32'h0000_3002, 32'h0,         0, 32'h1122_3344, 0, 0, 32'h0,         4'b0000, 32'h0,         1, 1, 32'hCAFE_F00D));
      vecs.push_back(mk(1, 0, 3'd1, 32'h0000_3001, 32'h0,         0, 32'h0000_9ABC, 0, 0, 32'h0,         4'b0000, 32'h0,         1, 1, 32'hCAFE_F00D));
      vecs.push_back(mk(0, 1, 3'd2, 32'h0000_3000, 32'h0102_0304, 0, 32'h0,         0, 1, 32'h0000_3000, 4'b1111, 32'h0102_0304, 0, 2, 32'hCAFE_F00D));
`else
      vecs.push_back(mk(1, 0, 3'd2, 32'h0000_3002, 32'h0,         0, 32'h1122_3344, 0, 1, 32'h0000_3000, 4'b0000, 32'h0,         0, 2, 32'h1122_3344));
      vecs.push_back(mk(1, 0, 3'd1, 32'h0000_3001, 32'h0,         0, 32'h0000_9ABC, 0, 1, 32'h0000_3000, 4'b0000, 32'h0,         0, 2, 32'hFFFF_9ABC));
      vecs.push_back(mk(0, 1, 3'd2, 32'h0000_3000, 32'h0102_0304, 0, 32'h0,         0, 1, 32'h0000_3000, 4'b1111, 32'h0102_0304, 0, 2, 32'hFFFF_9ABC));
`endif
      // Ready after 5 waits with a stray start mid-wait, then timeout, then ready on the last allowed cycle.
      vecs.push_back(mk(1, 0, 3'd2, 32'h0000_5000, 32'h0,         5, 32'h0BAD_F00D, 1, 1, 32'h0000_5000, 4'b0000, 32'h0,         0, 7, 32'h0BAD_F00D));
      vecs.push_back(mk(1, 0, 3'd2, 32'h0000_5004, 32'h0,       100, 32'h9999_9999, 0, 1, 32'h0000_5004, 4'b0000, 32'h0,         1, 9, 32'h0BAD_F00D));
      vecs.push_back(mk(1, 0, 3'd5, 32'h0000_5006, 32'h0,         7, 32'hA1B2_C3D4, 0, 1, 32'h0000_5004, 4'b0000, 32'h0,         0, 9, 32'h0000_A1B2));
      vecs.push_back(mk(1, 0, 3'd4, 32'h0000_5003, 32'h0,         0, 32'h8000_0000, 0, 1, 32'h0000_5000, 4'b0000, 32'h0,         0, 2, 32'h0000_0080));

      // Reset state.
      #3;
      check("reset mem_valid", {31'd0, mem_valid}, 32'd0);
      check("reset busy", {31'd0, busy}, 32'd0);
      repeat (2) @(negedge clk);
      check("reset outputs", {mem_addr ^ mem_wdata, 24'd0, mem_wstrb, done, fault, dbg_state}, 32'd0);
      check("reset load_result", load_result, 32'd0);
      rst = 1'b0;

      // Table of transactions.
      for (int i = 0; i < vecs.size(); i++) begin
         exp_q.push_back(vecs[i].e_res);
         run_txn(vecs[i], o);
         check($sformatf("v%0d done seen", i), {31'd0, o.done_seen}, 32'd1);
         check($sformatf("v%0d done cycle", i), o.done_cyc, vecs[i].e_done);
         check($sformatf("v%0d fault", i), {31'd0, o.fault}, {31'd0, vecs[i].e_fault});
         check($sformatf("v%0d busy in done", i), {31'd0, o.busy}, 32'd1);
         check($sformatf("v%0d valid cycles", i), o.valid_cycles,
               vecs[i].bus ? vecs[i].e_done - 1 : 0);
         if (vecs[i].bus) begin
            check($sformatf("v%0d mem_addr", i), o.addr, vecs[i].e_addr);
            check($sformatf("v%0d wstrb", i), {28'd0, o.strb}, {28'd0, vecs[i].e_strb});
            check($sformatf("v%0d stable", i), {31'd0, o.unstable}, 32'd0);
            if (vecs[i].st) check($sformatf("v%0d wdata", i), o.wdata, vecs[i].e_wdata);
         end
         exp_res = exp_q.pop_front();
         check($sformatf("v%0d load_result", i), o.result, exp_res);
         @(negedge clk);
         check($sformatf("v%0d after done", i), {28'd0, done, fault, busy, mem_valid}, 32'd0);
         check($sformatf("v%0d back to idle", i), {30'd0, dbg_state}, 32'd0);
      end

      // Start with both or neither operation selected is not a request.
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         start = 1'b1; is_load = (k == 0); is_store = (k == 0); funct3 = 3'd2; address = 32'h6000;
         @(negedge clk);
         start = 1'b0;
         repeat (2) begin
            check($sformatf("bad start %0d quiet", k), {29'd0, busy, done, mem_valid}, 32'd0);
            @(negedge clk);
         end
      end

      // Reset asserted mid-REQ clears outputs without a clock edge.
      @(negedge clk);
      start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2; address = 32'h0000_7008;
      mem_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("mid-REQ mem_valid before rst", {31'd0, mem_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst mid-REQ mem_valid", {31'd0, mem_valid}, 32'd0);
      check("rst mid-REQ busy", {31'd0, busy}, 32'd0);
      check("rst mid-REQ mem_addr", mem_addr, 32'd0);
      check("rst mid-REQ load_result", load_result, 32'd0);
      check("rst mid-REQ state", {30'd0, dbg_state}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_txn(mk(1, 0, 3'd2, 32'h0000_7008, 32'h0, 0, 32'h55AA_33CC, 0, 1, 32'h0000_7008,
                 4'b0000, 32'h0, 0, 2, 32'h55AA_33CC), o);
      check("post-rst done cycle", o.done_cyc, 2);
      check("post-rst mem_addr", o.addr, 32'h0000_7008);
      check("post-rst fault", {31'd0, o.fault}, 32'd0);
      check("post-rst load_result", o.result, 32'h55AA_33CC);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
